sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce_pkg.sv | 22 ++
 rtl/sw_debounce_bit.sv | 76 +++++++
 rtl/sw_debounce.sv | 33 +++
 tb/tb_sw_debounce.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared constants and types for the switch debouncer.
// The default debounce window is derived from the board clock and the desired settle time.
package sw_debounce_pkg;

  localparam int SYS_CLK_HZ          = 27_000_000;
  localparam int DEBOUNCE_MS         = 10;
  localparam int DEBOUNCE_CYCLES_DEF = (SYS_CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int SW_WIDTH            = 16;
  localparam int CNT_W_DEF           = 19;

  // IDLE: synchronized input agrees with the stable level; COUNT: it disagrees.
  typedef enum logic {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } db_state_e;

  // True when the debounce window is non-zero and its terminal count fits the counter.
  function automatic bit cycles_fit(input int cycles, input int cnt_w);
    return (cycles >= 1) && (longint'(cycles) < (longint'(1) << cnt_w));
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// Single-bit debouncer: 2-flop synchronizer, qualification counter and stable register.
// A level must hold for DEBOUNCE_CYCLES synchronized cycles before it is accepted.
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic sw_o,
  output logic chg_o
);

  if (!cycles_fit(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_cycles
    $error("debounce_bit: DEBOUNCE_CYCLES must satisfy 1 <= DEBOUNCE_CYCLES < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             chg_q;
  logic             chg_d;
  db_state_e        state;

  // The state is implied by the data registers, so it is decoded rather than stored.
  assign state = (s2_q != stable_q) ? DB_COUNT : DB_IDLE;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    chg_d    = 1'b0;
    case (state)
      DB_IDLE: begin
        cnt_d = '0;
      end
      DB_COUNT: begin
        if (cnt_q == CNT_LAST) begin
          stable_d = s2_q;
          chg_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      chg_q    <= 1'b0;
    end else begin
      s1_q     <= sw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      chg_q    <= chg_d;
    end
  end

  assign sw_o  = stable_q;
  assign chg_o = chg_q;

endmodule

// File: rtl/sw_debounce.sv
// Debounces a bank of WIDTH independent switches and flags which bits changed.
// chg_o is the OR of the registered per-bit change flags, so it aligns with sw_o.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic             chg_o,
  output logic [WIDTH-1:0] chg_mask_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk   (clk),
      .rst   (rst),
      .sw_i  (sw_i[i]),
      .sw_o  (sw_o[i]),
      .chg_o (chg_mask_o[i])
    );
  end

  assign chg_o = |chg_mask_o;

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce with a short debounce window (4 cycles).
// Expected change events are queued at drive time and matched when chg_o fires.
module tb_sw_debounce;

  localparam int W   = 16;
  localparam int DEB = 4;
  // A value driven just after edge c is observed just after edge c + DEB + 2.
  localparam int LAT = DEB + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_i;
  logic [W-1:0] sw_o;
  logic         chg_o;
  logic [W-1:0] chg_mask_o;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [W-1:0] exp_mask_q[$];
  logic [W-1:0] exp_sw_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] model_q = '0;
  logic [W-1:0] last_sw = '0;

  sw_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (19)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_i       (sw_i),
    .sw_o       (sw_o),
    .chg_o      (chg_o),
    .chg_mask_o (chg_mask_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      last_sw = '0;
    end else begin
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        n_checks++;
        $display("FAIL missed_change: expected at cycle %0d, no chg_o by cycle %0d (mask %h)",
                 exp_cyc_q[0], cyc, exp_mask_q[0]);
        void'(exp_mask_q.pop_front());
        void'(exp_sw_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
      n_checks++;
      if (chg_o !== (|chg_mask_o))
        $display("FAIL chg_or: chg_o=%b chg_mask_o=%h at cycle %0d", chg_o, chg_mask_o, cyc);
      else n_pass++;
      if (chg_o === 1'b1) begin
        if (exp_mask_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_chg: mask=%h sw_o=%h at cycle %0d", chg_mask_o, sw_o, cyc);
        end else begin
          logic [W-1:0] em;
          logic [W-1:0] es;
          int           ec;
          em = exp_mask_q.pop_front();
          es = exp_sw_q.pop_front();
          ec = exp_cyc_q.pop_front();
          n_checks++;
          if (chg_mask_o !== em) $display("FAIL chg_mask: got %h expected %h", chg_mask_o, em);
          else n_pass++;
          n_checks++;
          if (sw_o !== es) $display("FAIL sw_o_value: got %h expected %h", sw_o, es);
          else n_pass++;
          n_checks++;
          if (cyc !== ec) $display("FAIL chg_cycle: got %0d expected %0d", cyc, ec);
          else n_pass++;
        end
      end else begin
        n_checks++;
        if (sw_o !== last_sw)
          $display("FAIL sw_o_hold: got %h expected %h (no chg_o) at cycle %0d", sw_o, last_sw, cyc);
        else n_pass++;
      end
      last_sw = sw_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [W-1:0] v);
    logic [W-1:0] m;
    m = v ^ model_q;
    if (m != '0) begin
      exp_mask_q.push_back(m);
      exp_sw_q.push_back(v);
      exp_cyc_q.push_back(cyc + LAT);
      model_q = v;
    end
  endtask

  // Drive v at a negedge and keep it for 'hold' cycles; 'qual' marks a change that must be accepted.
  task automatic drive(input logic [W-1:0] v, input bit qual, input int hold);
    @(negedge clk);
    sw_i = v;
    if (qual) push_exp(v);
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && exp_cyc_q.size() > 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_cyc_q.size() != 0) begin
      $display("FAIL %s_drain: %0d expected changes still pending", name, exp_cyc_q.size());
      exp_mask_q.delete();
      exp_sw_q.delete();
      exp_cyc_q.delete();
    end else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst  = 1'b1;
    sw_i = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sw_o !== '0) $display("FAIL reset_sw_o: got %h expected 0000", sw_o); else n_pass++;
    n_checks++;
    if (chg_o !== 1'b0) $display("FAIL reset_chg_o: got %b expected 0", chg_o); else n_pass++;
    n_checks++;
    if (chg_mask_o !== '0) $display("FAIL reset_mask: got %h expected 0000", chg_mask_o); else n_pass++;
    #2 rst = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (sw_o !== '0) $display("FAIL idle_sw_o: got %h expected 0000", sw_o); else n_pass++;
  endtask

  task automatic test_clean_step();
    drive(16'h0001, 1'b1, 1);
    wait_drain("clean_rise");
    drive(16'h0000, 1'b1, 1);
    wait_drain("clean_fall");
  endtask

  task automatic test_glitch();
    drive(16'h0008, 1'b0, 3);
    drive(16'h0000, 1'b0, 1);
    repeat (12) @(negedge clk);
    n_checks++;
    if (sw_o !== 16'h0000) $display("FAIL glitch_sw_o: got %h expected 0000", sw_o); else n_pass++;
    // A pulse of exactly DEB cycles is the shortest that is accepted, both edges.
    drive(16'h0020, 1'b1, DEB);
    drive(16'h0000, 1'b1, 1);
    wait_drain("min_pulse");
  endtask

  task automatic test_bounce();
    drive(16'h0001, 1'b0, 1);
    drive(16'h0000, 1'b0, 1);
    drive(16'h0001, 1'b0, 1);
    drive(16'h0000, 1'b0, 1);
    drive(16'h0001, 1'b1, 1);
    wait_drain("bounce");
    n_checks++;
    if (sw_o !== 16'h0001) $display("FAIL bounce_sw_o: got %h expected 0001", sw_o); else n_pass++;
    drive(16'h0000, 1'b1, 1);
    wait_drain("bounce_release");
  endtask

  task automatic test_simultaneous();
    drive(16'h8001, 1'b1, 1);
    wait_drain("simul_rise");
    drive(16'h0000, 1'b1, 1);
    wait_drain("simul_fall");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] v;
      v = W'($urandom_range(0, 16'hFFFF));
      drive(v, 1'b1, $urandom_range(DEB, DEB + 3));
    end
    wait_drain("back_to_back");
    n_checks++;
    if (sw_o !== model_q) $display("FAIL b2b_final: got %h expected %h", sw_o, model_q); else n_pass++;
  endtask

  task automatic test_reset_mid_count();
    drive(16'h0F00, 1'b1, 1);
    wait_drain("pre_reset");
    drive(16'h00FF, 1'b0, 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (sw_o !== '0) $display("FAIL midrst_sw_o: got %h expected 0000", sw_o); else n_pass++;
    n_checks++;
    if (chg_mask_o !== '0 || chg_o !== 1'b0)
      $display("FAIL midrst_chg: got chg=%b mask=%h expected 0/0000", chg_o, chg_mask_o);
    else n_pass++;
    model_q = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sw_o !== '0) $display("FAIL midrst_hold: got %h expected 0000", sw_o); else n_pass++;
    #2 rst = 1'b0;
    push_exp(16'h00FF);
    wait_drain("midrst_release");
  endtask

  task automatic test_power_up();
    @(negedge clk);
    #2 rst = 1'b1;
    sw_i    = 16'hFFFF;
    model_q = '0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    push_exp(16'hFFFF);
    wait_drain("power_up");
    n_checks++;
    if (sw_o !== 16'hFFFF) $display("FAIL power_up_sw_o: got %h expected ffff", sw_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_count();
    test_power_up();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
